// File: rtl/float_types_pkg.sv
// ---------------------------------------------------------------------------
// float_types_pkg
//   Shared types for the FP summator result path.
//   float_point_num : IEEE-754 single precision {sign, exp[7:0], mant[22:0]}
//   num_status_t    : classification the summator attaches to every result
//   fp_result_t     : one stored result, status above value
// ---------------------------------------------------------------------------
package float_types_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } float_point_num;

    typedef enum logic [1:0] {
        ST_NORM = 2'b00,
        ST_ZERO = 2'b01,
        ST_INF  = 2'b10,
        ST_NAN  = 2'b11
    } num_status_t;

    typedef struct packed {
        num_status_t    status;
        float_point_num value;
    } fp_result_t;

endpackage

// File: rtl/fp_sum_result_collector_fifo.sv
// ---------------------------------------------------------------------------
// fp_result_fifo
//   First-word fall-through FIFO for fp_result_t entries.
//   Ports:
//     clk, rst     clock / asynchronous active-high reset
//     clr          synchronous clear of pointers (contents become invisible)
//     push, wr_data  write request and entry
//     pop          read request (ignored while empty)
//     rd_data      head entry, forced to zero while empty
//     level        entries held, full, empty
//   A push is refused when full unless a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module fp_result_fifo
    import float_types_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type T     = fp_result_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  T                         wr_data,
    input  logic                     pop,
    output T                         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           do_push;
    logic           do_pop;

    // Extra MSB on each pointer distinguishes full from empty when the
    // address bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage is not reset; entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign rd_data = empty ? T'('0) : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/fp_sum_result_collector.sv
// ---------------------------------------------------------------------------
// fp_sum_result_collector
//   Sink for the pipelined FP summator result stream. Every valid result is
//   buffered; results arriving at a full FIFO (with no pop that cycle) are
//   dropped, counted and flagged. The FIFO head is offered on a ready/valid
//   port.
//   Ports:
//     clk_i, rst_i      clock / asynchronous active-high reset
//     flush_i           synchronous clear of FIFO, flags and counters
//     vld_i, answer_i, num_status_i   incoming result (no backpressure)
//     vld_o, rdy_i, answer_o, num_status_o   outgoing ready/valid head
//     level_o, full_o   occupancy
//     ovf_o             sticky "a result was dropped"
//     drop_cnt_o, nan_cnt_o, inf_cnt_o   saturating event counters
// ---------------------------------------------------------------------------
module fp_sum_result_collector
    import float_types_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    vld_i,
    input  float_point_num          answer_i,
    input  num_status_t             num_status_i,
    output logic                    vld_o,
    input  logic                    rdy_i,
    output float_point_num          answer_o,
    output num_status_t             num_status_o,
    output logic [$clog2(DEPTH):0]  level_o,
    output logic                    full_o,
    output logic                    ovf_o,
    output logic [CNT_W-1:0]        drop_cnt_o,
    output logic [CNT_W-1:0]        nan_cnt_o,
    output logic [CNT_W-1:0]        inf_cnt_o
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    fp_result_t wr_entry;
    fp_result_t head;
    logic       empty;
    logic       pop;
    logic       accept;
    logic       drop;

    // Flush wins over everything in its cycle: no pop, no push, no counting.
    assign pop    = !empty && rdy_i && !flush_i;
    assign accept = vld_i && !flush_i && (!full_o || pop);
    assign drop   = vld_i && !flush_i && full_o && !pop;

    assign wr_entry.status = num_status_i;
    assign wr_entry.value  = answer_i;

    fp_result_fifo #(
        .DEPTH (DEPTH),
        .T     (fp_result_t)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .clr     (flush_i),
        .push    (accept),
        .wr_data (wr_entry),
        .pop     (pop),
        .rd_data (head),
        .level   (level_o),
        .full    (full_o),
        .empty   (empty)
    );

    assign vld_o        = !empty;
    assign answer_o     = head.value;
    assign num_status_o = head.status;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_o      <= 1'b0;
            drop_cnt_o <= '0;
            nan_cnt_o  <= '0;
            inf_cnt_o  <= '0;
        end else if (flush_i) begin
            ovf_o      <= 1'b0;
            drop_cnt_o <= '0;
            nan_cnt_o  <= '0;
            inf_cnt_o  <= '0;
        end else begin
            if (drop) begin
                ovf_o      <= 1'b1;
                drop_cnt_o <= sat_inc(drop_cnt_o);
            end
            if (accept && num_status_i == ST_NAN) nan_cnt_o <= sat_inc(nan_cnt_o);
            if (accept && num_status_i == ST_INF) inf_cnt_o <= sat_inc(inf_cnt_o);
        end
    end

endmodule
